fetch_prefetch_queue: RTL and testbench

- Instruction prefetch buffer between the instruction memory port and the fetch stage.
- Lets the fetch stage tolerate an instruction memory with variable latency and a ready/valid handshake.
- Runs ahead of fetch by up to DEPTH instructions and delivers {pc, instr} pairs in program order.
- On redirect (taken branch/jal/jalr from decode), discards every buffered and in-flight fetch and restarts at the new PC.

---
 rtl/fetch_prefetch_queue.sv | 145 ++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: runs ahead of fetch by up to DEPTH words over a
// ready/valid memory port, delivers {pc, instr} in order, flushes on redirect.
module fetch_prefetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic [XLEN-1:0]          mem_req_addr,
   input  logic                     mem_rsp_valid,
   input  logic [XLEN-1:0]          mem_rsp_data,
   input  logic                     redirect,
   input  logic [XLEN-1:0]          redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_instr,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     proto_err
);

   localparam int              PW      = $clog2(DEPTH);
   localparam logic [PW+1:0]   DEPTH_B = (PW+2)'(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW:0]      alloc_ptr;
   logic [PW:0]      fill_ptr;
   logic [PW:0]      read_ptr;
   logic [PW:0]      drop_cnt;
   logic [PW:0]      drop_nxt;
   logic [XLEN-1:0]  fetch_pc;

   logic [XLEN-1:0]  slot_pc    [DEPTH];
   logic [XLEN-1:0]  slot_instr [DEPTH];
   logic [DEPTH-1:0] slot_filled;

   logic [PW-1:0]    alloc_idx;
   logic [PW-1:0]    fill_idx;
   logic [PW-1:0]    read_idx;
   logic [PW:0]      live_inflight;
   logic [PW+1:0]    budget;

   logic             req_fire;
   logic             pop_fire;
   logic             rsp_drop;
   logic             rsp_fill;
   logic             rsp_orphan;

   assign alloc_idx     = alloc_ptr[PW-1:0];
   assign fill_idx      = fill_ptr[PW-1:0];
   assign read_idx      = read_ptr[PW-1:0];

   assign occupancy     = alloc_ptr - read_ptr;
   assign live_inflight = alloc_ptr - fill_ptr;
   assign budget        = {1'b0, occupancy} + {1'b0, drop_cnt};

   // Responses still owed to flushed requests count against the window, so
   // the memory never has more than DEPTH requests outstanding.
   assign mem_req_valid = !rst && !redirect && (budget < DEPTH_B);
   assign mem_req_addr  = fetch_pc;

   assign out_valid     = slot_filled[read_idx];
   assign out_pc        = slot_pc[read_idx];
   assign out_instr     = slot_instr[read_idx];

   assign req_fire      = mem_req_valid && mem_req_ready;
   assign pop_fire      = out_valid && out_ready && !redirect;
   assign rsp_drop      = mem_rsp_valid && (drop_cnt != '0);
   assign rsp_orphan    = mem_rsp_valid && (drop_cnt == '0) && (live_inflight == '0);
   assign rsp_fill      = mem_rsp_valid && (drop_cnt == '0) && (live_inflight != '0)
                          && !redirect;

   // A response arriving with a redirect retires an old drop first, otherwise
   // it belongs to one of the live slots being flushed.
   always_comb begin
      drop_nxt = drop_cnt;
      if (redirect) begin
         drop_nxt = drop_cnt + live_inflight;
         if (mem_rsp_valid && !rsp_orphan) begin
            drop_nxt = drop_nxt - 1'b1;
         end
      end else if (rsp_drop) begin
         drop_nxt = drop_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc  <= RESET_PC;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         read_ptr  <= '0;
         drop_cnt  <= '0;
         proto_err <= 1'b0;
      end else begin
         drop_cnt  <= drop_nxt;
         proto_err <= proto_err | rsp_orphan;
         if (redirect) begin
            fetch_pc <= redirect_pc;
            fill_ptr <= alloc_ptr;
            read_ptr <= alloc_ptr;
         end else begin
            if (req_fire) begin
               fetch_pc  <= fetch_pc + XLEN'(4);
               alloc_ptr <= alloc_ptr + 1'b1;
            end
            if (rsp_fill) begin
               fill_ptr <= fill_ptr + 1'b1;
            end
            if (pop_fire) begin
               read_ptr <= read_ptr + 1'b1;
            end
         end
      end
   end

   // Slot storage; allocate, fill and pop never touch the same slot in one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_filled <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            slot_pc[i]    <= '0;
            slot_instr[i] <= '0;
         end
      end else if (redirect) begin
         slot_filled <= '0;
      end else begin
         if (req_fire) begin
            slot_pc[alloc_idx]     <= fetch_pc;
            slot_filled[alloc_idx] <= 1'b0;
         end
         if (rsp_fill) begin
            slot_instr[fill_idx]  <= mem_rsp_data;
            slot_filled[fill_idx] <= 1'b1;
         end
         if (pop_fire) begin
            slot_filled[read_idx] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: streaming, backpressure, redirect
// flushes with dropped responses, request stall, async reset and proto_err.
module tb_fetch_prefetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [2:0]  occupancy;
   logic        proto_err;

   int n_assert = 0;
   int n_fail   = 0;

   fetch_prefetch_queue dut (
      .clk           (clk),
      .rst           (rst),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pc        (out_pc),
      .out_instr     (out_instr),
      .occupancy     (occupancy),
      .proto_err     (proto_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Leaves the bench at posedge+1 of the first cycle after reset release.
   task automatic do_reset();
      rst           = 1'b1;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      redirect      = 1'b0;
      out_ready     = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // reset values
      tick();
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_proto_err", 32'(proto_err), 32'd0);

      // streaming: 1-cycle memory latency, fetch always ready
      do_reset();
      mem_req_ready = 1'b1;
      out_ready     = 1'b1;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) tick();
         mem_rsp_valid = (k >= 1);
         mem_rsp_data  = (k >= 1) ? instr_of(32'(4 * (k - 1))) : 32'd0;
         #1;
         chk("stream_req_valid", 32'(mem_req_valid), 32'd1);
         chk("stream_req_addr", mem_req_addr, 32'(4 * k));
         if (k >= 2) begin
            chk("stream_out_valid", 32'(out_valid), 32'd1);
            chk("stream_out_pc", out_pc, 32'(4 * (k - 2)));
            chk("stream_out_instr", out_instr, instr_of(32'(4 * (k - 2))));
         end else begin
            chk("stream_out_valid_early", 32'(out_valid), 32'd0);
         end
      end

      // backpressure: queue fills at 4, then drains in order
      do_reset();
      mem_req_ready = 1'b1;
      out_ready     = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) tick();
         mem_rsp_valid = (k >= 1);
         mem_rsp_data  = (k >= 1) ? instr_of(32'(4 * (k - 1))) : 32'd0;
         #1;
         if (k < 4) chk("full_req_addr", mem_req_addr, 32'(4 * k));
      end
      chk("full_req_valid", 32'(mem_req_valid), 32'd0);
      chk("full_occupancy", 32'(occupancy), 32'd4);
      tick();
      mem_rsp_valid = 1'b0;
      out_ready     = 1'b1;
      #1;
      chk("full_hold_occupancy", 32'(occupancy), 32'd4);
      chk("full_hold_req_valid", 32'(mem_req_valid), 32'd0);
      chk("drain_pc0", out_pc, 32'h0);
      tick();
      #1;
      chk("drain_pc4", out_pc, 32'h4);
      chk("resume_req_valid", 32'(mem_req_valid), 32'd1);
      chk("resume_req_addr", mem_req_addr, 32'h10);
      tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = instr_of(32'h10);
      #1;
      chk("drain_pc8", out_pc, 32'h8);
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      chk("drain_pcC", out_pc, 32'hC);
      chk("drain_instrC", out_instr, instr_of(32'hC));
      tick();
      #1;
      chk("drain_pc10_valid", 32'(out_valid), 32'd1);
      chk("drain_pc10", out_pc, 32'h10);
      chk("drain_instr10", out_instr, instr_of(32'h10));

      // redirect with three requests outstanding
      do_reset();
      mem_req_ready = 1'b1;
      out_ready     = 1'b1;
      #1;
      tick();
      tick();
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      #1;
      chk("rd3_occupancy_before", 32'(occupancy), 32'd3);
      chk("rd3_req_blocked", 32'(mem_req_valid), 32'd0);
      tick();
      redirect = 1'b0;
      #1;
      chk("rd3_occupancy_after", 32'(occupancy), 32'd0);
      chk("rd3_req_valid", 32'(mem_req_valid), 32'd1);
      chk("rd3_req_addr", mem_req_addr, 32'h100);
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_0000;
      #1;
      chk("rd3_window_full", 32'(mem_req_valid), 32'd0);
      chk("rd3_drop1_out_valid", 32'(out_valid), 32'd0);
      tick();
      mem_rsp_data = 32'hDEAD_0004;
      #1;
      chk("rd3_drop2_out_valid", 32'(out_valid), 32'd0);
      tick();
      mem_rsp_data = 32'hDEAD_0008;
      #1;
      chk("rd3_drop3_out_valid", 32'(out_valid), 32'd0);
      tick();
      mem_rsp_data = instr_of(32'h100);
      #1;
      chk("rd3_live_rsp_out_valid", 32'(out_valid), 32'd0);
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      chk("rd3_out_valid", 32'(out_valid), 32'd1);
      chk("rd3_out_pc", out_pc, 32'h100);
      chk("rd3_out_instr", out_instr, instr_of(32'h100));

      // redirect coinciding with a response and a pop, 2 live unfilled slots
      do_reset();
      mem_req_ready = 1'b1;
      out_ready     = 1'b0;
      #1;
      tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = instr_of(32'h0);
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      chk("rdc_head_valid", 32'(out_valid), 32'd1);
      chk("rdc_head_pc", out_pc, 32'h0);
      tick();
      redirect      = 1'b1;
      redirect_pc   = 32'h200;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = instr_of(32'h4);
      out_ready     = 1'b1;
      #1;
      chk("rdc_occupancy_before", 32'(occupancy), 32'd3);
      chk("rdc_req_blocked", 32'(mem_req_valid), 32'd0);
      tick();
      redirect      = 1'b0;
      mem_rsp_valid = 1'b0;
      #1;
      chk("rdc_occupancy_after", 32'(occupancy), 32'd0);
      chk("rdc_out_valid_after", 32'(out_valid), 32'd0);
      chk("rdc_req_addr", mem_req_addr, 32'h200);
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hBAD0_0008;
      #1;
      chk("rdc_occupancy_new", 32'(occupancy), 32'd1);
      chk("rdc_drop_out_valid", 32'(out_valid), 32'd0);
      tick();
      mem_rsp_data = instr_of(32'h200);
      #1;
      chk("rdc_live_rsp_out_valid", 32'(out_valid), 32'd0);
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      chk("rdc_out_valid", 32'(out_valid), 32'd1);
      chk("rdc_out_pc", out_pc, 32'h200);
      chk("rdc_out_instr", out_instr, instr_of(32'h200));

      // request held stable while memory is not ready
      do_reset();
      mem_req_ready = 1'b1;
      out_ready     = 1'b0;
      #1;
      tick();
      tick();
      mem_req_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) tick();
         #1;
         chk("stall_req_valid", 32'(mem_req_valid), 32'd1);
         chk("stall_req_addr", mem_req_addr, 32'h8);
      end
      tick();
      mem_req_ready = 1'b1;
      #1;
      chk("stall_release_addr", mem_req_addr, 32'h8);
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = instr_of(32'h0);
      #1;
      chk("stall_next_addr", mem_req_addr, 32'hC);
      chk("stall_occupancy", 32'(occupancy), 32'd3);
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      chk("pre_rst_out_valid", 32'(out_valid), 32'd1);

      // asynchronous reset mid-cycle with occupancy 3
      #3;
      rst = 1'b1;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_req_valid", 32'(mem_req_valid), 32'd0);
      chk("async_occupancy", 32'(occupancy), 32'd0);
      tick();
      tick();
      rst           = 1'b0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h1234_5678;
      #1;
      chk("post_rst_req_valid", 32'(mem_req_valid), 32'd1);
      chk("post_rst_req_addr", mem_req_addr, 32'h0);
      chk("post_rst_proto_clear", 32'(proto_err), 32'd0);

      // response with nothing outstanding
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      chk("proto_err_set", 32'(proto_err), 32'd1);
      chk("proto_out_valid", 32'(out_valid), 32'd0);
      chk("proto_occupancy", 32'(occupancy), 32'd0);
      tick();
      tick();
      #1;
      chk("proto_err_sticky", 32'(proto_err), 32'd1);
      do_reset();
      #1;
      chk("proto_err_rst", 32'(proto_err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
